// File: rtl/cfg_serializer.sv
// cfg_serializer: backend configuration sequencer.
// Holds the backend in reset, shifts an 8-bit configuration frame out MSB first
// on a divided serial clock, then waits for the backend's ready flag with a timeout.
module cfg_serializer #(
  parameter int unsigned CLK_DIV       = 4,
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned READY_TIMEOUT = 1024
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_start,
  input  logic [1:0] i_gainA1,
  input  logic [2:0] i_gainA2,
  input  logic       i_en1,
  input  logic       i_en2,
  input  logic       i_envco,
  input  logic       i_ready,
  output logic       o_resetbAll,
  output logic       o_sclk,
  output logic       o_sdout,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_timeout
);

  // One shared counter covers both the reset hold and the ready timeout.
  localparam int unsigned CNT_MAX = (RST_CYCLES > READY_TIMEOUT) ? RST_CYCLES : READY_TIMEOUT;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned PH_W    = $clog2(CLK_DIV);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    RESET_HOLD = 3'd1,
    SHIFT      = 3'd2,
    WAIT_READY = 3'd3,
    DONE       = 3'd4,
    ERROR      = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       frame_q, frame_d;
  logic             rdy_meta_q, rdy_sync_q;

  logic resetb_d, sclk_d, sdout_d, busy_d, done_d, timeout_d;

  // Two-flop synchronizer for the asynchronous ready flag.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      rdy_meta_q <= 1'b0;
      rdy_sync_q <= 1'b0;
    end else begin
      rdy_meta_q <= i_ready;
      rdy_sync_q <= rdy_meta_q;
    end
  end

  // State, counters and captured frame.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      phase_q <= '0;
      bit_q   <= '0;
      frame_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
      frame_q <= frame_d;
    end
  end

  // Next-state logic; outputs are derived from the next state so they register cleanly.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    phase_d   = phase_q;
    bit_d     = bit_q;
    frame_d   = frame_q;
    timeout_d = o_timeout;

    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          frame_d   = {i_gainA1, i_gainA2, i_en1, i_en2, i_envco};
          timeout_d = 1'b0;
          cnt_d     = '0;
          state_d   = RESET_HOLD;
        end
      end
      RESET_HOLD: begin
        if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
          cnt_d   = '0;
          phase_d = '0;
          bit_d   = '0;
          state_d = SHIFT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SHIFT: begin
        if (phase_q == PH_W'(CLK_DIV - 1)) begin
          phase_d = '0;
          if (bit_q == 3'd7) begin
            cnt_d   = '0;
            state_d = WAIT_READY;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      WAIT_READY: begin
        // Ready is checked first so it wins over a simultaneous timeout.
        if (rdy_sync_q) begin
          state_d = DONE;
        end else if (cnt_q == CNT_W'(READY_TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          state_d   = ERROR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      ERROR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Serial clock low in the first half of each bit, high in the second half.
    resetb_d = (state_d != RESET_HOLD);
    sclk_d   = (state_d == SHIFT) && (phase_d >= PH_W'(CLK_DIV / 2));
    sdout_d  = (state_d == SHIFT) && frame_d[~bit_d];
    busy_d   = (state_d != IDLE);
    done_d   = (state_d == DONE);
  end

  // Registered outputs.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_resetbAll <= 1'b0;
      o_sclk      <= 1'b0;
      o_sdout     <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_timeout   <= 1'b0;
    end else begin
      o_resetbAll <= resetb_d;
      o_sclk      <= sclk_d;
      o_sdout     <= sdout_d;
      o_busy      <= busy_d;
      o_done      <= done_d;
      o_timeout   <= timeout_d;
    end
  end

endmodule

// File: tb/tb_cfg_serializer.sv
// Self-checking bench for cfg_serializer: default configuration plus a fast
// CLK_DIV=2 / RST_CYCLES=1 instance sharing the same stimulus.
module tb_cfg_serializer;

  localparam int unsigned D1_DIV = 4;
  localparam int unsigned D1_RST = 16;
  localparam int unsigned D1_TO  = 1024;
  localparam int unsigned D2_DIV = 2;
  localparam int unsigned D2_RST = 1;
  localparam int unsigned D2_TO  = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] g1;
  logic [2:0] g2;
  logic       e1, e2, ev;
  logic       rdy;

  logic d1_resetb, d1_sclk, d1_sdout, d1_busy, d1_done, d1_timeout;
  logic d2_resetb, d2_sclk, d2_sdout, d2_busy, d2_done, d2_timeout;

  logic sel = 1'b0;
  wire m_resetb  = sel ? d2_resetb  : d1_resetb;
  wire m_sclk    = sel ? d2_sclk    : d1_sclk;
  wire m_sdout   = sel ? d2_sdout   : d1_sdout;
  wire m_busy    = sel ? d2_busy    : d1_busy;
  wire m_done    = sel ? d2_done    : d1_done;
  wire m_timeout = sel ? d2_timeout : d1_timeout;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  cfg_serializer #(.CLK_DIV(D1_DIV), .RST_CYCLES(D1_RST), .READY_TIMEOUT(D1_TO)) u_dut1 (
    .i_clk(clk), .i_reset(rst), .i_start(start), .i_gainA1(g1), .i_gainA2(g2),
    .i_en1(e1), .i_en2(e2), .i_envco(ev), .i_ready(rdy),
    .o_resetbAll(d1_resetb), .o_sclk(d1_sclk), .o_sdout(d1_sdout),
    .o_busy(d1_busy), .o_done(d1_done), .o_timeout(d1_timeout)
  );

  cfg_serializer #(.CLK_DIV(D2_DIV), .RST_CYCLES(D2_RST), .READY_TIMEOUT(D2_TO)) u_dut2 (
    .i_clk(clk), .i_reset(rst), .i_start(start), .i_gainA1(g1), .i_gainA2(g2),
    .i_en1(e1), .i_en2(e2), .i_envco(ev), .i_ready(rdy),
    .o_resetbAll(d2_resetb), .o_sclk(d2_sclk), .o_sdout(d2_sdout),
    .o_busy(d2_busy), .o_done(d2_done), .o_timeout(d2_timeout)
  );

  // Reference model: the frame as the ordered list of bits the backend should see.
  function automatic logic [7:0] expected_bits(input logic [1:0] a1, input logic [2:0] a2,
                                               input logic b1, input logic b2, input logic bv);
    logic [7:0] r;
    bit q[$];
    q = {};
    for (int i = 1; i >= 0; i--) q.push_back(a1[i]);
    for (int i = 2; i >= 0; i--) q.push_back(a2[i]);
    q.push_back(b1);
    q.push_back(b2);
    q.push_back(bv);
    r = '0;
    foreach (q[i]) r = {r[6:0], q[i]};
    return r;
  endfunction

  task automatic randomize_frame();
    g1 = 2'($urandom);
    g2 = 3'($urandom);
    e1 = 1'($urandom);
    e2 = 1'($urandom);
    ev = 1'($urandom);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    int n;
    n = 0;
    @(negedge clk);
    while ((d1_busy || d2_busy) && n < 3000) begin
      n++;
      @(negedge clk);
    end
    ok = (n < 3000);
  endtask

  // Watches one sequence from the cycle after start: reset-low length, SHIFT
  // length, bits seen on sclk rises, longest sclk-high run and sdout changes
  // while sclk is high or at a rise. Returns at the first WAIT_READY sample.
  task automatic observe(output int rst_low, output int shift_cyc, output logic [7:0] bits,
                         output int nrise, output int max_hi, output int glitches, output bit ok);
    int budget, hi;
    logic ps, pd;
    rst_low = 0; shift_cyc = 0; bits = '0; nrise = 0; max_hi = 0; glitches = 0; ok = 1'b1; hi = 0;
    @(negedge clk);
    budget = 0;
    while (m_resetb == 1'b0 && budget < 100) begin
      rst_low++; budget++;
      @(negedge clk);
    end
    if (budget >= 100) ok = 1'b0;
    ps = 1'b0;
    pd = m_sdout;
    budget = 0;
    while (!(nrise == 8 && m_sclk == 1'b0) && budget < 400) begin
      if (m_sclk && !ps) begin
        bits = {bits[6:0], m_sdout};
        nrise++;
        if (m_sdout !== pd) glitches++;
      end else if (m_sclk && ps && m_sdout !== pd) begin
        glitches++;
      end
      hi = m_sclk ? hi + 1 : 0;
      if (hi > max_hi) max_hi = hi;
      ps = m_sclk; pd = m_sdout;
      shift_cyc++; budget++;
      @(negedge clk);
    end
    if (budget >= 400) ok = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({d1_resetb, d1_sclk, d1_sdout, d1_busy, d1_done, d1_timeout} !== 6'b0)
      $display("FAIL reset_outputs: got %b expected 000000",
               {d1_resetb, d1_sclk, d1_sdout, d1_busy, d1_done, d1_timeout});
    else passed++;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({d1_resetb, d1_busy, d1_done} !== 3'b100)
      $display("FAIL reset_release: resetb/busy/done got %b expected 100", {d1_resetb, d1_busy, d1_done});
    else passed++;
  endtask

  task automatic test_basic_done();
    int rl, sc, nr, mh, gl, n;
    logic [7:0] bits;
    bit ok;
    sel = 1'b0;
    g1 = 2'b10; g2 = 3'b101; e1 = 1'b1; e2 = 1'b1; ev = 1'b0; rdy = 1'b0;
    pulse_start();
    observe(rl, sc, bits, nr, mh, gl, ok);
    total++;
    if (!ok || rl != 16 || sc != 32)
      $display("FAIL basic_timing: ok=%0d rst_low=%0d shift=%0d expected 1/16/32", ok, rl, sc);
    else passed++;
    total++;
    if (bits !== 8'b10101110 || bits !== expected_bits(g1, g2, e1, e2, ev) || gl != 0)
      $display("FAIL basic_bits: got %b glitches=%0d expected 10101110 glitches=0", bits, gl);
    else passed++;
    total++;
    if ({m_sclk, m_sdout, m_busy} !== 3'b001)
      $display("FAIL wait_entry: sclk/sdout/busy got %b expected 001", {m_sclk, m_sdout, m_busy});
    else passed++;
    repeat (10) @(negedge clk);
    rdy = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!m_done && n < 20);
    total++;
    if (n != 3) $display("FAIL done_latency: got %0d cycles expected 3", n);
    else passed++;
    @(negedge clk);
    total++;
    if ({m_done, m_busy, m_timeout} !== 3'b000)
      $display("FAIL done_pulse: done/busy/timeout got %b expected 000", {m_done, m_busy, m_timeout});
    else passed++;
    rdy = 1'b0;
    wait_idle(ok);
  endtask

  task automatic test_timeout();
    int rl, sc, nr, mh, gl, n, dn;
    logic [7:0] bits;
    bit ok;
    sel = 1'b0;
    randomize_frame();
    rdy = 1'b0;
    pulse_start();
    observe(rl, sc, bits, nr, mh, gl, ok);
    n = 0; dn = 0;
    while (!m_timeout && n < 2000) begin
      @(negedge clk);
      n++;
      if (m_done) dn++;
    end
    total++;
    if (n != 1024 || dn != 0)
      $display("FAIL timeout_latency: got %0d cycles done=%0d expected 1024 done=0", n, dn);
    else passed++;
    repeat (20) @(negedge clk);
    total++;
    if ({m_timeout, m_busy, m_done} !== 3'b100)
      $display("FAIL timeout_sticky: timeout/busy/done got %b expected 100", {m_timeout, m_busy, m_done});
    else passed++;
    pulse_start();
    @(negedge clk);
    total++;
    if ({m_timeout, m_busy} !== 2'b01)
      $display("FAIL timeout_clear: timeout/busy got %b expected 01", {m_timeout, m_busy});
    else passed++;
    observe(rl, sc, bits, nr, mh, gl, ok);
    rdy = 1'b1;
    wait_idle(ok);
    rdy = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_start_ignored();
    int rl, sc, nr, mh, gl, extra;
    logic [7:0] bits, exp;
    bit ok;
    sel = 1'b0;
    randomize_frame();
    exp = expected_bits(g1, g2, e1, e2, ev);
    pulse_start();
    rdy = 1'b1;
    fork
      observe(rl, sc, bits, nr, mh, gl, ok);
      begin
        repeat (D1_RST + 6) @(negedge clk);
        g1 = ~g1; g2 = ~g2; e1 = ~e1; e2 = ~e2; ev = ~ev;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
      end
    join
    total++;
    if (!ok || bits !== exp || sc != 32)
      $display("FAIL frame_locked: got %b shift=%0d expected %b shift=32", bits, sc, exp);
    else passed++;
    total++;
    if ({m_sclk, m_sdout, m_busy, m_done} !== 4'b0010)
      $display("FAIL ready_early_wait: sclk/sdout/busy/done got %b expected 0010",
               {m_sclk, m_sdout, m_busy, m_done});
    else passed++;
    @(negedge clk);
    total++;
    if (m_done !== 1'b1) $display("FAIL ready_early_done: got %b expected 1", m_done);
    else passed++;
    rdy = 1'b0;
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (m_busy || !m_resetb) extra++;
    end
    total++;
    if (extra != 0) $display("FAIL no_queued_start: busy cycles got %0d expected 0", extra);
    else passed++;
  endtask

  task automatic test_reset_abort();
    int rl, sc, nr, mh, gl, n, dn;
    logic [7:0] bits, exp;
    bit ok;
    sel = 1'b0;
    rdy = 1'b0;
    randomize_frame();
    pulse_start();
    n = 0;
    while (!m_resetb && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (3 * D1_DIV + D1_DIV / 2) @(negedge clk);
    total++;
    if ({m_sclk, m_busy} !== 2'b11) $display("FAIL abort_precond: sclk/busy got %b expected 11", {m_sclk, m_busy});
    else passed++;
    rst = 1'b1;
    #1;
    total++;
    if ({m_resetb, m_sclk, m_sdout, m_busy} !== 4'b0)
      $display("FAIL abort_async: resetb/sclk/sdout/busy got %b expected 0000",
               {m_resetb, m_sclk, m_sdout, m_busy});
    else passed++;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    dn = 0;
    repeat (60) begin
      @(negedge clk);
      if (m_done || m_busy) dn++;
    end
    total++;
    if (dn != 0 || m_resetb !== 1'b1)
      $display("FAIL abort_quiet: done/busy cycles %0d resetb %b expected 0 and 1", dn, m_resetb);
    else passed++;
    randomize_frame();
    exp = expected_bits(g1, g2, e1, e2, ev);
    pulse_start();
    observe(rl, sc, bits, nr, mh, gl, ok);
    total++;
    if (!ok || bits !== exp || nr != 8)
      $display("FAIL abort_restart: got %b rises=%0d expected %b rises=8", bits, nr, exp);
    else passed++;
    rdy = 1'b1;
    wait_idle(ok);
    rdy = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_random_frames();
    int rl, sc, nr, mh, gl, n, dly;
    logic [7:0] bits, exp;
    bit ok;
    sel = 1'b0;
    for (int k = 0; k < 4; k++) begin
      randomize_frame();
      exp = expected_bits(g1, g2, e1, e2, ev);
      pulse_start();
      observe(rl, sc, bits, nr, mh, gl, ok);
      total++;
      if (!ok || bits !== exp || gl != 0 || mh != D1_DIV / 2)
        $display("FAIL rand_frame%0d: got %b glitches=%0d hi=%0d expected %b 0 %0d",
                 k, bits, gl, mh, exp, D1_DIV / 2);
      else passed++;
      dly = $urandom_range(0, 20);
      repeat (dly) @(negedge clk);
      rdy = 1'b1;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!m_done && n < 20);
      total++;
      if (n != 3) $display("FAIL rand_done%0d: got %0d cycles expected 3", k, n);
      else passed++;
      rdy = 1'b0;
      wait_idle(ok);
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic test_fast_div();
    int rl, sc, nr, mh, gl, n;
    logic [7:0] bits, exp;
    bit ok;
    wait_idle(ok);
    repeat (4) @(negedge clk);
    sel = 1'b1;
    rdy = 1'b0;
    randomize_frame();
    exp = expected_bits(g1, g2, e1, e2, ev);
    pulse_start();
    observe(rl, sc, bits, nr, mh, gl, ok);
    total++;
    if (!ok || rl != 1 || sc != 16 || mh != 1)
      $display("FAIL fast_timing: ok=%0d rst_low=%0d shift=%0d hi=%0d expected 1/1/16/1", ok, rl, sc, mh);
    else passed++;
    total++;
    if (bits !== exp || gl != 0) $display("FAIL fast_bits: got %b glitches=%0d expected %b", bits, gl, exp);
    else passed++;
    rdy = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!m_done && n < 20);
    total++;
    if (n != 3 || m_timeout !== 1'b0)
      $display("FAIL fast_done: got %0d cycles timeout=%b expected 3 and 0", n, m_timeout);
    else passed++;
    rdy = 1'b0;
    sel = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; rdy = 1'b0;
    g1 = '0; g2 = '0; e1 = 1'b0; e2 = 1'b0; ev = 1'b0;
    test_reset();
    test_basic_done();
    test_timeout();
    test_start_ignored();
    test_reset_abort();
    test_random_frames();
    test_fast_div();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/cfg_serializer.md
CFG_SERIALIZER -- requirements
Module: cfg_serializer

Interface
REQ-001 Parameter CLK_DIV, 4, i_clk cycles per serial bit; SHALL be even and >= 2.
REQ-002 Parameter RST_CYCLES, 16, number of i_clk cycles o_resetbAll is held low per configuration sequence.
REQ-003 Parameter READY_TIMEOUT, 1024, maximum i_clk cycles spent waiting for i_ready after the frame is sent.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-005 i_clk  in  1  system clock; all state changes on its rising edge.
REQ-006 i_reset  in  1  asynchronous, active-high reset.
REQ-007 i_start  in  1  request to run one configuration sequence; sampled only in IDLE.
REQ-008 i_gainA1  in  2  stage-1 gain code.
REQ-009 i_gainA2  in  3  stage-2 gain code.
REQ-010 i_en1, i_en2, i_envco  in  1 each  enables for stage 1, stage 2 and the VCO.
REQ-011 i_ready  in  1  configuration-accepted flag from the backend; asynchronous to i_clk.
REQ-012 o_resetbAll  out  1  active-low reset to the backend.
REQ-013 o_sclk  out  1  serial clock to the backend; idles low.
REQ-014 o_sdout  out  1  serial data to the backend.
REQ-015 o_busy  out  1  high from sequence start until it completes.
REQ-016 o_done  out  1  one-cycle pulse on successful completion.
REQ-017 o_timeout  out  1  sticky error flag; cleared by the next accepted i_start or by reset.

Function
REQ-018 The FSM SHALL have the states IDLE, RESET_HOLD, SHIFT, WAIT_READY, DONE and ERROR.
REQ-019 In IDLE with i_start=1, the block SHALL capture frame[7:0] = {i_gainA1, i_gainA2, i_en1, i_en2, i_envco}, clear o_timeout and enter RESET_HOLD; later input changes SHALL NOT affect the frame.
REQ-020 In RESET_HOLD, o_resetbAll SHALL be 0 for exactly RST_CYCLES cycles, after which the FSM enters SHIFT with o_resetbAll=1.
REQ-021 In SHIFT, bits SHALL be sent MSB first, each occupying CLK_DIV cycles.
REQ-022 Within each bit period, o_sclk SHALL be low for the first CLK_DIV/2 cycles and high for the last CLK_DIV/2 cycles.
REQ-023 o_sdout SHALL change only while o_sclk is low and SHALL be stable across every o_sclk rising edge.
REQ-024 The SHIFT state SHALL last exactly 8*CLK_DIV cycles, producing exactly 8 o_sclk rising edges, and then enter WAIT_READY with o_sclk=0 and o_sdout=0.
REQ-025 i_ready SHALL pass through a 2-flop synchronizer; only the synchronized value is used.
REQ-026 In WAIT_READY, a synchronized ready of 1 SHALL cause the FSM to enter DONE.
REQ-027 In WAIT_READY, after READY_TIMEOUT cycles without ready the FSM SHALL enter ERROR.
REQ-028 If ready and timeout occur in the same cycle, ready SHALL win.
REQ-029 Ready seen in RESET_HOLD or SHIFT SHALL be ignored.
REQ-030 DONE SHALL assert o_done for exactly 1 cycle and then return to IDLE.
REQ-031 ERROR SHALL set o_timeout, keep o_done=0 and return to IDLE after 1 cycle.
REQ-032 o_busy SHALL be 1 in every state except IDLE.
REQ-033 i_start while o_busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-034 All outputs SHALL be registered.

Reset
REQ-035 While i_reset=1, the block SHALL hold: state=IDLE, o_resetbAll=0, o_sclk=0, o_sdout=0, o_busy=0, o_done=0, o_timeout=0, synchronizer flops=0, all counters=0.
REQ-036 On release of i_reset, o_resetbAll SHALL go to 1 on the first i_clk edge and the block SHALL wait in IDLE.
REQ-037 Asserting i_reset in any state SHALL immediately apply the REQ-035 values, abort any frame in progress, and produce no o_done pulse.

Verification
REQ-038 Defaults, gainA1=2'b10, gainA2=3'b101, en1=1, en2=1, envco=0, start pulse -> o_resetbAll low 16 cycles; sdout sampled on sclk rise = 1,0,1,0,1,1,1,0; SHIFT lasts 32 cycles.
REQ-039 i_ready raised 10 cycles into WAIT_READY -> o_done 1-cycle pulse 3 cycles later; o_busy falls with return to IDLE; o_timeout=0.
REQ-040 i_ready held 0 -> ERROR after 1024 WAIT_READY cycles; o_timeout=1 and stays 1; the next start clears it.
REQ-041 i_start pulsed during SHIFT, and i_ready=1 throughout SHIFT -> frame unchanged, no second sequence, WAIT_READY still entered.
REQ-042 i_reset asserted mid-SHIFT (after bit 3) -> o_sclk, o_sdout, o_busy=0 and o_resetbAll=0 asynchronously; no o_done; a fresh start sends the full 8 bits.
REQ-043 CLK_DIV=2, RST_CYCLES=1 -> 1-cycle sclk high/low phases; frame bits correct; done path functional.
